// File: rtl/rv32_exec_mem_skid.sv
// rv32_exec_mem_skid: two-entry in-order skid buffer between the exec and mem
// stages. The head entry drives out_* directly from registers, and in_ready is
// decoded from the registered occupancy only.
// Optional feature macro: RV32_EXMEM_FWD_EN enables the head-entry bypass on
// fwd_*. When the macro is undefined, fwd_* are tied to zero.
module rv32_exec_mem_skid (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_rd,
  input  logic        in_wb_en,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  // Payload packing: {pc[31:0], result[31:0], rd[4:0], wb_en}
  logic [1:0]  r_cnt;
  logic [69:0] r_head;
  logic [69:0] r_tail;
  logic [69:0] w_in;
  logic        w_push;
  logic        w_pop;

  assign w_in      = {in_pc, in_result, in_rd, in_wb_en};
  assign in_ready  = (r_cnt != CNT_FULL);
  assign out_valid = (r_cnt != CNT_EMPTY);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign out_pc     = r_head[69:38];
  assign out_result = r_head[37:6];
  assign out_rd     = r_head[5:1];
  assign out_wb_en  = r_head[0];

  // Occupancy and head entry. The head is cleared whenever the buffer empties.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= CNT_EMPTY;
      r_head <= '0;
    end else if (flush) begin
      r_cnt  <= CNT_EMPTY;
      r_head <= '0;
    end else begin
      case (r_cnt)
        CNT_EMPTY: begin
          if (w_push) begin
            r_cnt  <= CNT_ONE;
            r_head <= w_in;
          end
        end
        CNT_ONE: begin
          if (w_push && w_pop) begin
            r_head <= w_in;
          end else if (w_push) begin
            r_cnt <= CNT_FULL;
          end else if (w_pop) begin
            r_cnt  <= CNT_EMPTY;
            r_head <= '0;
          end
        end
        CNT_FULL: begin
          if (w_pop) begin
            r_cnt  <= CNT_ONE;
            r_head <= r_tail;
          end
        end
        default: begin
          r_cnt  <= CNT_EMPTY;
          r_head <= '0;
        end
      endcase
    end
  end

  // Second entry. It is only captured when a push lands behind a stalled head,
  // and it is only read after it has been written, so it needs no reset.
  always_ff @(posedge clk) begin
    if ((r_cnt == CNT_ONE) && w_push && !w_pop) begin
      r_tail <= w_in;
    end
  end

`ifdef RV32_EXMEM_FWD_EN
  assign fwd_valid = out_valid && out_wb_en && (out_rd != 5'd0);
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_rv32_exec_mem_skid.sv
// Testbench for rv32_exec_mem_skid. A reference queue models the FIFO.
// Expected entries are pushed when an accepted push is driven, and they are
// compared and popped when the DUT hands its head entry to the mem stage.
module tb_rv32_exec_mem_skid;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [69:0] q[$];

  rv32_exec_mem_skid dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_result(out_result), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset empties the reference model immediately, just as it empties the DUT.
  always @(negedge resetn) q.delete();

  // Scoreboard. Inputs settle 1 ns after each rising edge, so the handshakes
  // seen at the falling edge are the ones the next rising edge will take.
  always @(negedge clk) begin
    logic        e_ready, e_valid, e_fv;
    logic [69:0] e_head, act;
    logic [4:0]  e_frd;
    logic [31:0] e_fdata;
    if (resetn) begin
      e_ready = (q.size() < 2);
      e_valid = (q.size() > 0);
      e_head  = e_valid ? q[0] : 70'd0;
      act     = {out_pc, out_result, out_rd, out_wb_en};
`ifdef RV32_EXMEM_FWD_EN
      e_fv    = e_valid && e_head[0] && (e_head[5:1] != 5'd0);
      e_frd   = e_head[5:1];
      e_fdata = e_head[37:6];
`else
      e_fv    = 1'b0;
      e_frd   = 5'd0;
      e_fdata = 32'd0;
`endif
      n_cmp++;
      if (in_ready !== e_ready) begin
        n_err++;
        $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, in_ready, e_ready);
      end
      n_cmp++;
      if (out_valid !== e_valid) begin
        n_err++;
        $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, out_valid, e_valid);
      end
      n_cmp++;
      if (act !== e_head) begin
        n_err++;
        $display("FAIL sb_head t=%0t got=%h exp=%h", $time, act, e_head);
      end
      n_cmp++;
      if ({fwd_valid, fwd_rd, fwd_data} !== {e_fv, e_frd, e_fdata}) begin
        n_err++;
        $display("FAIL sb_fwd t=%0t got=%b/%0d/%h exp=%b/%0d/%h", $time,
                 fwd_valid, fwd_rd, fwd_data, e_fv, e_frd, e_fdata);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (e_valid && out_ready) void'(q.pop_front());
        if (in_valid && e_ready) q.push_back({in_pc, in_result, in_rd, in_wb_en});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] res,
                       input logic [4:0] rd, input logic wb);
    in_valid  = v;
    in_pc     = pc;
    in_result = res;
    in_rd     = rd;
    in_wb_en  = wb;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    #13;
    n_cmp++;
    if ({out_valid, out_pc, out_result, out_rd, out_wb_en} !== 71'd0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b pc=%h res=%h exp all zero",
               out_valid, out_pc, out_result);
    end
    n_cmp++;
    if ({fwd_valid, fwd_rd, fwd_data} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_fwd got=%b/%0d/%h exp zero", fwd_valid, fwd_rd, fwd_data);
    end
    tick();
    resetn = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h100, 32'hDEADBEEF, 5'd5, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    n_cmp++;
    if ({out_valid, out_pc, out_result, out_rd, out_wb_en} !==
        {1'b1, 32'h100, 32'hDEADBEEF, 5'd5, 1'b1}) begin
      n_err++;
      $display("FAIL single_out got v=%b pc=%h res=%h rd=%0d wb=%b exp 1/100/deadbeef/5/1",
               out_valid, out_pc, out_result, out_rd, out_wb_en);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== 32'd0) begin
      n_err++;
      $display("FAIL single_empty got v=%b res=%h exp 0/0", out_valid, out_result);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h1, 5'd1, 1'b1);
    tick();
    drive(1'b1, 32'h204, 32'h2, 5'd2, 1'b1);
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || out_result !== 32'h1) begin
      n_err++;
      $display("FAIL bp_full got rdy=%b res=%h exp 0/1", in_ready, out_result);
    end
    drive(1'b1, 32'h208, 32'h3, 5'd3, 1'b1);
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || out_result !== 32'h1) begin
      n_err++;
      $display("FAIL bp_hold got rdy=%b res=%h exp 0/1", in_ready, out_result);
    end
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 32'h2) begin
      n_err++;
      $display("FAIL bp_second got v=%b res=%h exp 1/2", out_valid, out_result);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== 32'h0) begin
      n_err++;
      $display("FAIL bp_drained got v=%b res=%h exp 0/0", out_valid, out_result);
    end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    drive(1'b1, 32'h300, 32'h10, 5'd4, 1'b1);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 32'h304, 32'h20, 5'd6, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 32'h20) begin
      n_err++;
      $display("FAIL pushpop_one got v=%b rdy=%b res=%h exp 1/1/20",
               out_valid, in_ready, out_result);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'hA1, 5'd1, 1'b1);
    tick();
    drive(1'b1, 32'h404, 32'hA2, 5'd2, 1'b1);
    tick();
    drive(1'b1, 32'h408, 32'hA3, 5'd3, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_empty got v=%b res=%h rdy=%b exp 0/0/1",
               out_valid, out_result, in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_lost got v=%b res=%h exp v=0", out_valid, out_result);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h500, 32'hB1, 5'd1, 1'b1);
    tick();
    drive(1'b1, 32'h504, 32'hB2, 5'd2, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd0) begin
      n_err++;
      $display("FAIL areset_mid got v=%b rdy=%b res=%h exp 0/1/0",
               out_valid, in_ready, out_result);
    end
    tick();
    resetn = 1'b1;
    drive(1'b1, 32'h600, 32'hC0FFEE, 5'd9, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 32'hC0FFEE || out_pc !== 32'h600) begin
      n_err++;
      $display("FAIL areset_first got v=%b pc=%h res=%h exp 1/600/c0ffee",
               out_valid, out_pc, out_result);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_fwd();
    out_ready = 1'b0;
    drive(1'b1, 32'h700, 32'h99, 5'd0, 1'b1);
    tick();
    n_cmp++;
    if (fwd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fwd_rd0 got=%b exp=0", fwd_valid);
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h704, 32'h55, 5'd7, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    out_ready = 1'b0;
    n_cmp++;
`ifdef RV32_EXMEM_FWD_EN
    if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd7, 32'h55}) begin
      n_err++;
      $display("FAIL fwd_rd7 got=%b/%0d/%h exp=1/7/55", fwd_valid, fwd_rd, fwd_data);
    end
`else
    if ({fwd_valid, fwd_rd, fwd_data} !== 38'd0) begin
      n_err++;
      $display("FAIL fwd_off got=%b/%0d/%h exp=0/0/0", fwd_valid, fwd_rd, fwd_data);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6 && out_valid; i++) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain got v=%b pending=%0d exp 0/0", out_valid, q.size());
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_push_pop();
    test_flush();
    test_async_reset();
    test_fwd();
    test_random();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_exec_mem_skid.md
RV32_EXEC_MEM_SKID -- requirements
Module: rv32_exec_mem_skid

Interface
REQ-001 SHALL have no parameters; depth fixed at 2 entries, payload fixed at 70 bits {pc, result, rd, wb_en}.
REQ-002 SHALL provide port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL provide port: resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: in_valid  input  1  exec stage presents an instruction result.
REQ-005 SHALL provide port: in_ready  output  1  buffer can accept this cycle.
REQ-006 SHALL provide port: in_pc  input  32  instruction PC.
REQ-007 SHALL provide port: in_result  input  32  exec result word (ALU or mul unit).
REQ-008 SHALL provide port: in_rd  input  5  destination register index.
REQ-009 SHALL provide port: in_wb_en  input  1  register write-back enable.
REQ-010 SHALL provide port: flush  input  1  synchronous discard of all held entries.
REQ-011 SHALL provide port: out_valid  output  1  head entry valid toward mem stage.
REQ-012 SHALL provide port: out_ready  input  1  mem stage accepts head entry.
REQ-013 SHALL provide ports: out_pc  output  32, out_result  output  32, out_rd  output  5, out_wb_en  output  1  head entry payload.
REQ-014 SHALL provide ports (see REQ-031): fwd_valid  output  1, fwd_rd  output  5, fwd_data  output  32  bypass toward exec operand mux.

Function
REQ-015 SHALL be a 2-entry in-order FIFO; states EMPTY, ONE, FULL encoded by an entry count.
REQ-016 SHALL drive in_ready from registered state only: 1 in EMPTY and ONE, 0 in FULL; never combinationally from out_ready.
REQ-017 SHALL push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-018 SHALL drive out_valid = 1 in ONE and FULL, 0 in EMPTY; out_* SHALL come from registers (head entry).
REQ-019 SHALL give 1-cycle latency: payload pushed at edge N is on out_* after edge N when buffer was EMPTY.
REQ-020 SHALL implement transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with new payload at head; FULL+pop->ONE with second entry promoted to head; otherwise hold.
REQ-021 SHALL hold out_* stable while out_valid && !out_ready.
REQ-022 SHALL, on flush, enter EMPTY at next edge regardless of in_valid/out_ready; the same-cycle input is dropped and no pop is counted.
REQ-023 SHALL set out_* to zero whenever state becomes EMPTY (pop-to-empty or flush).
REQ-024 SHALL never reorder, duplicate or drop entries except on flush.
REQ-025 SHALL pass payload bits unmodified; no arithmetic on result.

Reset
REQ-026 SHALL, on resetn low, immediately enter EMPTY without waiting for clk.
REQ-027 SHALL reset out_valid=0, in_ready=1 (after release), out_pc=out_result=0, out_rd=0, out_wb_en=0, fwd_*=0.
REQ-028 SHALL discard all held entries when reset asserts mid-operation, including in FULL.
REQ-029 SHALL accept a push on the first rising edge after resetn deasserts.

Configuration
REQ-030 SHALL use macro RV32_EXMEM_FWD_EN to compile the forwarding ports' logic in or out; ports always exist.
REQ-031 SHALL, with RV32_EXMEM_FWD_EN defined, drive fwd_valid = out_valid && out_wb_en && out_rd != 0, fwd_rd = out_rd, fwd_data = out_result; without it, tie fwd_valid, fwd_rd, fwd_data to 0.

Verification
REQ-032 SHALL cover: push {pc=0x100,res=0xDEADBEEF,rd=5,wb=1} with out_ready=1 -> out_valid=1 with that payload next cycle, EMPTY the cycle after.
REQ-033 SHALL cover: out_ready=0, push A=0x1 then B=0x2 -> FULL, in_ready=0, third push 0x3 ignored; release out_ready -> outputs 0x1 then 0x2, 0x3 never appears.
REQ-034 SHALL cover: ONE holding 0x10, simultaneous push 0x20 and pop -> state ONE, out_result=0x20 next cycle.
REQ-035 SHALL cover: FULL plus flush with in_valid=1 -> EMPTY next cycle, out_valid=0, out_result=0, pushed word lost.
REQ-036 SHALL cover: resetn low asynchronously mid-cycle in FULL -> out_valid=0 before next edge; first post-reset push appears one cycle later.
REQ-037 SHALL cover: with RV32_EXMEM_FWD_EN, head rd=0,wb=1 -> fwd_valid=0; rd=7,wb=1,res=0x55 -> fwd_valid=1, fwd_rd=7, fwd_data=0x55; without macro all fwd_* = 0.
